// File: rtl/demux_sched_pkg.sv
// Shared types and lane-rotation helper for demux_sched.
// Optional feature: define DEMUX_SCHED_SKIP_EN to skip non-ready lanes at rotation.
package demux_sched_pkg;

   localparam int NLANE = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Lane that takes over when a burst completes.
   function automatic logic [SEL_W-1:0] next_lane(
      input logic [SEL_W-1:0] sel,
      input logic [NLANE-1:0] lane_ready
   );
      logic [SEL_W-1:0] w_nl;
      logic [SEL_W-1:0] w_cand;
      w_nl   = sel + SEL_W'(1);
      w_cand = '0;
`ifdef DEMUX_SCHED_SKIP_EN
      // Scan farthest-first so the nearest ready lane is the one that sticks.
      for (int k = NLANE - 1; k >= 1; k--) begin
         w_cand = sel + SEL_W'(k);
         if (lane_ready[w_cand]) begin
            w_nl = w_cand;
         end
      end
`endif
      return w_nl;
   endfunction

endpackage

// File: rtl/demux_dec.sv
// 2-to-4 demultiplexer decode with enable; turns lane select into one-hot valid.
import demux_sched_pkg::*;

module demux_dec (
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_en,
   output logic [NLANE-1:0] o_valid
);

   genvar gi;
   generate
      for (gi = 0; gi < NLANE; gi++) begin : g_lane
         assign o_valid[gi] = i_en & (i_sel == SEL_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/demux_sched.sv
// Round-robin burst scheduler driving the lane demux from one valid/ready stream.
// Build option: DEMUX_SCHED_SKIP_EN (see demux_sched_pkg::next_lane).
import demux_sched_pkg::*;

module demux_sched #(
   parameter int DW    = 8,
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   input  logic [NLANE-1:0] lane_ready,
   output logic [NLANE-1:0] out_valid,
   output logic [DW-1:0]    out_data,
   output logic [SEL_W-1:0] sel,
   output logic             en,
   output logic [7:0]       burst_cnt
);

   state_t           r_state;
   logic [SEL_W-1:0] r_sel;
   logic             r_en;
   logic [DW-1:0]    r_data;
   logic [7:0]       r_cnt;

   logic             w_lane_rdy;
   logic             w_dlv;
   logic             w_acc;
   logic             w_burst_end;
   logic [SEL_W-1:0] w_next_sel;

   assign w_lane_rdy  = lane_ready[r_sel];
   assign w_dlv       = r_en & w_lane_rdy;
   // A held word leaving this cycle frees the register for a new one.
   assign in_ready    = ~r_en | w_lane_rdy;
   assign w_acc       = in_valid & in_ready;
   assign w_burst_end = (r_cnt == 8'(BURST - 1));
   assign w_next_sel  = next_lane(r_sel, lane_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_en    <= 1'b0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_dlv) begin
            if (w_burst_end) begin
               r_cnt <= '0;
               r_sel <= w_next_sel;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end

         case (r_state)
            IDLE: begin
               if (w_acc) begin
                  r_data  <= in_data;
                  r_en    <= 1'b1;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               if (w_dlv) begin
                  if (w_acc) begin
                     r_data <= in_data;
                  end else begin
                     r_en    <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_en    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   demux_dec u_dec (
      .i_sel   (r_sel),
      .i_en    (r_en),
      .o_valid (out_valid)
   );

   assign out_data  = r_data;
   assign sel       = r_sel;
   assign en        = r_en;
   assign burst_cnt = r_cnt;

endmodule

// File: tb/tb_demux_sched.sv
// Self-checking bench for demux_sched: directed scenarios plus random traffic
// checked against a queue-based lane/burst model.
module tb_demux_sched;

   localparam int TB_BURST = 2;
`ifdef DEMUX_SCHED_SKIP_EN
   localparam logic [1:0] SKIP_SEL = 2'd2;
`else
   localparam logic [1:0] SKIP_SEL = 2'd1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [3:0] lane_ready;
   logic [3:0] out_valid;
   logic [7:0] out_data;
   logic [1:0] sel;
   logic       en;
   logic [7:0] burst_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the word currently owned by the demux, lane and words sent in burst.
   logic [7:0] m_held[$];
   int         m_lane;
   int         m_cnt;

   always #5 clk = ~clk;

   demux_sched #(.DW(8), .BURST(TB_BURST)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .lane_ready (lane_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .sel        (sel),
      .en         (en),
      .burst_cnt  (burst_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick_lane(input int cur, input logic [3:0] lr);
`ifdef DEMUX_SCHED_SKIP_EN
      for (int k = 1; k <= 3; k++) begin
         if (lr[(cur + k) % 4]) return (cur + k) % 4;
      end
`endif
      return (cur + 1) % 4;
   endfunction

   // One clock cycle: drive inputs, check the pre-edge state, advance the model.
   task automatic step(input logic iv, input logic [7:0] d, input logic [3:0] lr);
      logic exp_en, exp_rdy, dlv, acc;
      @(negedge clk);
      in_valid   = iv;
      in_data    = d;
      lane_ready = lr;
      #1;
      exp_en  = (m_held.size() != 0);
      exp_rdy = !exp_en || lr[m_lane];
      chk("in_ready", in_ready, exp_rdy);
      chk("en", en, exp_en);
      chk("sel", sel, m_lane);
      chk("burst_cnt", burst_cnt, m_cnt);
      chk("out_valid", out_valid, exp_en ? (4'b0001 << m_lane) : 4'b0000);
      if (exp_en) chk("out_data", out_data, m_held[0]);
      dlv = exp_en && lr[m_lane];
      acc = iv && exp_rdy;
      $display("t=%0t iv=%b d=%h lr=%b | rdy=%b sel=%0d en=%b ov=%b od=%h cnt=%0d dlv=%b acc=%b",
               $time, iv, d, lr, in_ready, sel, en, out_valid, out_data, burst_cnt, dlv, acc);
      if (dlv) begin
         void'(m_held.pop_front());
         m_cnt++;
         if (m_cnt == TB_BURST) begin
            m_cnt  = 0;
            m_lane = pick_lane(m_lane, lr);
         end
      end
      if (acc) m_held.push_back(d);
   endtask

   // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_sel", sel, 2'd0);
      chk("rst_en", en, 1'b0);
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_burst_cnt", burst_cnt, 8'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      m_held.delete();
      m_lane = 0;
      m_cnt  = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      lane_ready = 4'b1111;
      m_lane     = 0;
      m_cnt      = 0;

      // Reset then idle.
      do_reset();
      step(1'b0, 8'h00, 4'b1111);
      chk("idle_in_ready", in_ready, 1'b1);
      chk("idle_out_valid", out_valid, 4'b0000);

      // Streaming rotation, one word per cycle, wrap back to lane 0.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'(8'h10 + i), 4'b1111);
         if (i > 0) chk("stream_in_ready", in_ready, 1'b1);
      end
      step(1'b0, 8'h00, 4'b1111);
      chk("stream_last_lane", out_valid, 4'b1000);
      chk("stream_last_data", out_data, 8'h17);
      step(1'b0, 8'h00, 4'b1111);
      chk("stream_wrap_sel", sel, 2'd0);

      // Mid-burst reset discards the held word.
      step(1'b1, 8'h55, 4'b1111);
      step(1'b1, 8'h56, 4'b1111);
      do_reset();

      // Backpressure on lane 0.
      step(1'b1, 8'h20, 4'b1110);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 4'b1110);
         chk("bp_data", out_data, 8'h20);
         chk("bp_valid", out_valid, 4'b0001);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_cnt", burst_cnt, 8'd0);
      end
      step(1'b0, 8'h00, 4'b1111);
      step(1'b0, 8'h00, 4'b1111);
      chk("bp_cnt_after", burst_cnt, 8'd1);

      // Rotation with lanes 1 not ready: skip or strict round robin.
      do_reset();
      step(1'b1, 8'h40, 4'b1111);
      step(1'b1, 8'h41, 4'b1111);
      step(1'b0, 8'h00, 4'b1101);
      step(1'b1, 8'h42, 4'b1101);
      chk("skip_sel", sel, SKIP_SEL);
      step(1'b0, 8'h00, 4'b1101);
      chk("skip_hold_data", out_data, 8'h42);
      step(1'b0, 8'h00, 4'b1111);
      step(1'b0, 8'h00, 4'b1111);

      // Rotation with no other lane ready falls back to sel+1.
      do_reset();
      step(1'b1, 8'h44, 4'b1111);
      step(1'b1, 8'h45, 4'b1111);
      step(1'b0, 8'h00, 4'b0001);
      step(1'b0, 8'h00, 4'b0001);
      chk("none_ready_sel", sel, 2'd1);

      // Idle gap keeps burst position and lane.
      do_reset();
      step(1'b1, 8'h30, 4'b1111);
      step(1'b0, 8'h00, 4'b1111);
      step(1'b0, 8'h00, 4'b1111);
      step(1'b0, 8'h00, 4'b1111);
      chk("gap_en", en, 1'b0);
      chk("gap_valid", out_valid, 4'b0000);
      chk("gap_cnt", burst_cnt, 8'd1);
      step(1'b1, 8'h31, 4'b1111);
      step(1'b0, 8'h00, 4'b0000);
      chk("gap_lane", out_valid, 4'b0001);
      chk("gap_data", out_data, 8'h31);
      step(1'b0, 8'h00, 4'b1111);

      // Random traffic against the model, with one reset in the middle.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] lr;
         lr = 4'b0000;
         for (int b = 0; b < 4; b++) lr[b] = ($urandom_range(0, 3) != 0);
         if (i == 200) do_reset();
         step(1'($urandom_range(0, 1)), 8'($urandom), lr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
